muldiv_scheduler: RTL and testbench
===================================

Name: muldiv_scheduler

Overview:
- Sequences the multi-cycle multiplier and divider for the non-pipelined LEGv8 core.
- Sits between the decode-stage control outputs (mult_start, div_start, mult_mode, div_mode) and the execute-stage units.
- Issues one-cycle launch pulses, holds the core stalled while a unit runs, and serialises back-to-back or simultaneous requests.
- Raises a sticky timeout error if a unit never reports done.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles from launch to done before timeout; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
clk  input  1  single system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
mult_req  input  1  multiply requested by the decoded instruction (level, held while stalled)
div_req  input  1  divide requested by the decoded instruction (level, held while stalled)
mult_mode_in  input  2  multiplier mode from control
div_mode_in  input  1  divider mode from control
multiplier_done  input  1  multiplier result ready (single-cycle pulse)
divider_done  input  1  divider result ready (single-cycle pulse)
mult_go  output  1  one-cycle multiplier launch pulse
div_go  output  1  one-cycle divider launch pulse
mult_mode  output  2  mode latched at launch, stable while the unit runs
div_mode  output  1  mode latched at launch, stable while the unit runs
stall  output  1  freeze PC and decode
result_valid  output  1  one-cycle write-back strobe
result_sel  output  1  0 = multiplier result, 1 = divider result; valid with result_valid
busy  output  1  state is not IDLE
timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE, all outputs 0, cycle counter 0, div_pending 0. Reset takes effect from any state, including mid-operation. Units are not notified; any done pulse arriving after reset is ignored.
- States: IDLE, LAUNCH_M, RUN_M, LAUNCH_D, RUN_D, DRAIN, ERROR.
- IDLE:
  - stall = mult_req | div_req (combinational), so the core stalls in the request cycle.
  - mult_req only -> LAUNCH_M.
  - div_req only -> LAUNCH_D.
  - Both -> LAUNCH_M and set div_pending; the multiplier has priority.
  - mult_mode_in and div_mode_in are latched on the IDLE->LAUNCH edge.
- LAUNCH_M / LAUNCH_D:
  - mult_go / div_go is 1 for exactly this cycle.
  - Counter is cleared; stall = 1; next state RUN_M / RUN_D.
  - A done pulse during LAUNCH is ignored.
- RUN_M / RUN_D:
  - stall = 1; the counter increments each cycle.
  - The matching done pulse is accepted and the other unit's done is ignored.
  - On accepted done: if RUN_M with div_pending, clear div_pending and go to LAUNCH_D (no write-back for the multiply). Otherwise go to DRAIN with result_sel set for the finishing unit.
  - Counter reaching TIMEOUT_CYCLES with no done -> ERROR.
  - Done on the same cycle the counter reaches the limit counts as success.
- DRAIN:
  - result_valid = 1 and stall = 0 for exactly one cycle; the instruction retires at the end of this cycle.
  - mult_req/div_req are ignored here because they still belong to the retiring instruction.
  - Next state IDLE.
- ERROR:
  - timeout_err = 1, stall = 0, busy = 1, no go pulses.
  - Held until reset.
- Latency, with done returned N cycles after go (N ≥ 1):
  - Request cycle t (IDLE); go at t+1; done at t+1+N; result_valid at t+2+N.
  - stall is high from t through t+1+N.
  - Minimum request-to-write-back latency is 3 cycles (done 1 cycle after go).
- mult_mode and div_mode hold their latched values until the next launch.

Test Plan:
- Reset, then mult_req=1 with mode 2'b10 at cycle 0 and multiplier_done at cycle 5 -> mult_go high at cycle 1 only, mult_mode=2'b10 from cycle 1, stall high cycles 0–5, result_valid=1 and result_sel=0 at cycle 6, IDLE at cycle 7.
- mult_req and div_req together at cycle 0; multiplier_done at 4; divider_done at 9 -> mult_go@1, div_go@5, no result_valid at 5, result_valid with result_sel=1 @10, stall continuous 0–9.
- div_req at cycle 0 with divider_done asserted at cycle 1 (launch cycle) and never again, TIMEOUT_CYCLES=8 -> done ignored, ERROR at cycle 10, timeout_err=1 and stall=0 sticky until reset, which clears it.
- During RUN_D, pulse multiplier_done, then divider_done 3 cycles later -> the stray pulse causes no transition; DRAIN follows the divider_done only.
- Assert reset in RUN_M at cycle 3, then release with req low -> all outputs 0 next cycle; a late multiplier_done produces no result_valid.
- Hold mult_req high across DRAIN -> exactly one mult_go. If a new request is presented in the cycle after DRAIN, a second launch occurs.

Source files
------------

// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler: launches, stalls for and serialises the multi-cycle multiplier and divider, with a sticky timeout.
module muldiv_scheduler #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mult_req,
   input  logic       div_req,
   input  logic [1:0] mult_mode_in,
   input  logic       div_mode_in,
   input  logic       multiplier_done,
   input  logic       divider_done,
   output logic       mult_go,
   output logic       div_go,
   output logic [1:0] mult_mode,
   output logic       div_mode,
   output logic       stall,
   output logic       result_valid,
   output logic       result_sel,
   output logic       busy,
   output logic       timeout_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LAUNCH_M, RUN_M, LAUNCH_D, RUN_D, DRAIN, ERROR} state_t;
   state_t state, next;
   logic [CW-1:0] cnt;
   logic div_pending, sel, timed_out;
   // The counter holds completed RUN cycles, so this is the last cycle a done may still arrive.
   assign timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         div_pending <= 1'b0;
         sel <= 1'b0;
         mult_mode <= 2'b00;
         div_mode <= 1'b0;
      end else begin
         state <= next;
         cnt <= (state == RUN_M || state == RUN_D) ? cnt + CW'(1) : '0;
         if (state == IDLE && mult_req) mult_mode <= mult_mode_in;
         if (state == IDLE && div_req) div_mode <= div_mode_in;
         if (state == IDLE) div_pending <= mult_req & div_req;
         else if (state == RUN_M && multiplier_done) div_pending <= 1'b0;
         if (next == DRAIN) sel <= state == RUN_D;
      end
   end
   always_comb begin
      next = state;
      mult_go = 1'b0;
      div_go = 1'b0;
      stall = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: begin
            stall = mult_req | div_req;
            next = mult_req ? LAUNCH_M : div_req ? LAUNCH_D : IDLE;
         end
         LAUNCH_M: begin
            mult_go = 1'b1;
            stall = 1'b1;
            next = RUN_M;
         end
         RUN_M: begin
            stall = 1'b1;
            next = multiplier_done ? (div_pending ? LAUNCH_D : DRAIN) : timed_out ? ERROR : RUN_M;
         end
         LAUNCH_D: begin
            div_go = 1'b1;
            stall = 1'b1;
            next = RUN_D;
         end
         RUN_D: begin
            stall = 1'b1;
            next = divider_done ? DRAIN : timed_out ? ERROR : RUN_D;
         end
         DRAIN: begin
            result_valid = 1'b1;
            next = IDLE;
         end
         ERROR: next = ERROR;
         default: next = IDLE;
      endcase
   end
   assign result_sel = (state == DRAIN) & sel;
   assign busy = state != IDLE;
   assign timeout_err = state == ERROR;
endmodule

// File: tb/tb_muldiv_scheduler.sv
// tb_muldiv_scheduler: directed cycle-by-cycle checks of launch, serialisation, timeout and reset behaviour.
module tb_muldiv_scheduler;
   logic clk = 1'b0, reset = 1'b1, mult_req = 1'b0, div_req = 1'b0;
   logic [1:0] mult_mode_in = 2'b00;
   logic div_mode_in = 1'b0, multiplier_done = 1'b0, divider_done = 1'b0;
   logic mult_go, div_go, div_mode, stall, result_valid, result_sel, busy, timeout_err;
   logic [1:0] mult_mode;
   logic [6:0] o;
   int checks = 0, errors = 0;
   muldiv_scheduler #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .mult_req(mult_req), .div_req(div_req),
      .mult_mode_in(mult_mode_in), .div_mode_in(div_mode_in),
      .multiplier_done(multiplier_done), .divider_done(divider_done),
      .mult_go(mult_go), .div_go(div_go), .mult_mode(mult_mode), .div_mode(div_mode),
      .stall(stall), .result_valid(result_valid), .result_sel(result_sel),
      .busy(busy), .timeout_err(timeout_err)
   );
   always #5 clk = ~clk;
   // Flag order: mult_go div_go stall result_valid result_sel busy timeout_err
   assign o = {mult_go, div_go, stall, result_valid, result_sel, busy, timeout_err};
   task automatic step(input logic r, input logic mr, input logic dr, input logic [1:0] mm,
                       input logic dm, input logic md, input logic dd);
      @(posedge clk);
      #1;
      reset = r;
      mult_req = mr;
      div_req = dr;
      mult_mode_in = mm;
      div_mode_in = dm;
      multiplier_done = md;
      divider_done = dd;
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask
   initial begin
      step(1, 0, 0, 2'b00, 0, 0, 0);
      step(1, 0, 0, 2'b00, 0, 0, 0);
      step(0, 0, 0, 2'b00, 0, 0, 0);
      chk("reset_flags", 8'(o), 8'b0000000);
      chk("reset_modes", {5'd0, mult_mode, div_mode}, 8'd0);
      // Single multiply, done 4 cycles after go, request held through DRAIN
      step(0, 1, 0, 2'b10, 0, 0, 0); chk("m_c0", 8'(o), 8'b0010000);
      step(0, 1, 0, 2'b01, 0, 0, 0); chk("m_c1", 8'(o), 8'b1010010);
      chk("m_mode_c1", 8'(mult_mode), 8'b10);
      for (int i = 2; i <= 4; i++) begin
         step(0, 1, 0, 2'b01, 0, 0, 0); chk($sformatf("m_c%0d", i), 8'(o), 8'b0010010);
      end
      step(0, 1, 0, 2'b01, 0, 1, 0); chk("m_c5", 8'(o), 8'b0010010);
      step(0, 1, 0, 2'b01, 0, 0, 0); chk("m_c6_drain", 8'(o), 8'b0001010);
      chk("m_mode_c6", 8'(mult_mode), 8'b10);
      // New request right after DRAIN, minimum latency (done 1 cycle after go)
      step(0, 1, 0, 2'b01, 0, 0, 0); chk("m2_c0", 8'(o), 8'b0010000);
      step(0, 1, 0, 2'b01, 0, 0, 0); chk("m2_c1", 8'(o), 8'b1010010);
      chk("m2_mode", 8'(mult_mode), 8'b01);
      step(0, 1, 0, 2'b01, 0, 1, 0); chk("m2_c2", 8'(o), 8'b0010010);
      step(0, 1, 0, 2'b01, 0, 0, 0); chk("m2_c3_drain", 8'(o), 8'b0001010);
      step(0, 0, 0, 2'b00, 0, 0, 0); chk("m2_idle", 8'(o), 8'b0000000);
      // Simultaneous requests: multiply first, then divide
      step(0, 1, 1, 2'b11, 1, 0, 0); chk("md_c0", 8'(o), 8'b0010000);
      step(0, 1, 1, 2'b00, 0, 0, 0); chk("md_c1", 8'(o), 8'b1010010);
      step(0, 1, 1, 2'b00, 0, 0, 0); chk("md_c2", 8'(o), 8'b0010010);
      step(0, 1, 1, 2'b00, 0, 0, 0); chk("md_c3", 8'(o), 8'b0010010);
      step(0, 1, 1, 2'b00, 0, 1, 0); chk("md_c4", 8'(o), 8'b0010010);
      step(0, 1, 1, 2'b00, 0, 0, 0); chk("md_c5_divgo", 8'(o), 8'b0110010);
      chk("md_modes", {5'd0, mult_mode, div_mode}, 8'b111);
      for (int i = 6; i <= 8; i++) begin
         step(0, 1, 1, 2'b00, 0, 0, 0); chk($sformatf("md_c%0d", i), 8'(o), 8'b0010010);
      end
      step(0, 1, 1, 2'b00, 0, 0, 1); chk("md_c9", 8'(o), 8'b0010010);
      step(0, 1, 1, 2'b00, 0, 0, 0); chk("md_c10_drain", 8'(o), 8'b0001110);
      step(0, 0, 0, 2'b00, 0, 0, 0); chk("md_idle", 8'(o), 8'b0000000);
      // Divide with a stray multiplier_done while running
      step(0, 0, 1, 2'b00, 0, 0, 0); chk("d_c0", 8'(o), 8'b0010000);
      step(0, 0, 1, 2'b00, 1, 0, 0); chk("d_c1", 8'(o), 8'b0110010);
      chk("d_mode", 8'(div_mode), 8'b0);
      step(0, 0, 1, 2'b00, 0, 1, 0); chk("d_c2_stray", 8'(o), 8'b0010010);
      step(0, 0, 1, 2'b00, 0, 0, 0); chk("d_c3", 8'(o), 8'b0010010);
      step(0, 0, 1, 2'b00, 0, 0, 0); chk("d_c4", 8'(o), 8'b0010010);
      step(0, 0, 1, 2'b00, 0, 0, 1); chk("d_c5", 8'(o), 8'b0010010);
      step(0, 0, 1, 2'b00, 0, 0, 0); chk("d_c6_drain", 8'(o), 8'b0001110);
      step(0, 0, 0, 2'b00, 0, 0, 0); chk("d_idle", 8'(o), 8'b0000000);
      // Timeout: done only during LAUNCH_D, limit 8
      step(0, 0, 1, 2'b00, 1, 0, 0); chk("to_c0", 8'(o), 8'b0010000);
      step(0, 0, 1, 2'b00, 1, 0, 1); chk("to_c1", 8'(o), 8'b0110010);
      for (int i = 2; i <= 9; i++) begin
         step(0, 0, 1, 2'b00, 1, 0, 0); chk($sformatf("to_c%0d", i), 8'(o), 8'b0010010);
      end
      step(0, 0, 1, 2'b00, 1, 0, 0); chk("to_c10_err", 8'(o), 8'b0000011);
      step(0, 1, 1, 2'b00, 1, 1, 1); chk("to_c11_sticky", 8'(o), 8'b0000011);
      step(1, 0, 0, 2'b00, 0, 0, 0); chk("to_c12_rst", 8'(o), 8'b0000011);
      step(0, 0, 0, 2'b00, 0, 0, 0); chk("to_cleared", 8'(o), 8'b0000000);
      chk("to_modes_cleared", {5'd0, mult_mode, div_mode}, 8'd0);
      // Reset in the middle of a multiply
      step(0, 1, 0, 2'b11, 0, 0, 0); chk("r_c0", 8'(o), 8'b0010000);
      step(0, 1, 0, 2'b11, 0, 0, 0); chk("r_c1", 8'(o), 8'b1010010);
      chk("r_mode", 8'(mult_mode), 8'b11);
      step(0, 1, 0, 2'b11, 0, 0, 0); chk("r_c2", 8'(o), 8'b0010010);
      step(1, 1, 0, 2'b11, 0, 0, 0); chk("r_c3", 8'(o), 8'b0010010);
      step(0, 0, 0, 2'b00, 0, 0, 0); chk("r_c4", 8'(o), 8'b0000000);
      chk("r_c4_mode", 8'(mult_mode), 8'b00);
      step(0, 0, 0, 2'b00, 0, 1, 0); chk("r_c5_late_done", 8'(o), 8'b0000000);
      step(0, 0, 0, 2'b00, 0, 0, 0); chk("r_c6", 8'(o), 8'b0000000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
